branch_update_controller: RTL
=============================

BRANCH_UPDATE_CONTROLLER -- requirements
Module: branch_update_controller

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 32, PC and target width.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, in-flight branch entries; power of two, minimum 2.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 2, post-flush stall length; minimum 1.
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- push_valid  input  1  fetch has a predicted branch.
- push_ready  output  1  queue accepts a push.
- push_pc  input  ADDRESS_BITS  branch PC.
- push_pred_taken  input  1  predicted direction.
- push_pred_target  input  ADDRESS_BITS  predicted target.
- res_valid  input  1  execute has resolved the oldest branch.
- res_ready  output  1  resolution accepted.
- res_taken  input  1  actual direction.
- res_target  input  ADDRESS_BITS  actual target.
- flush_req  input  1  external pipeline flush.
- upd_valid  output  1  predictor update strobe; drives predictor update enable.
- upd_pc  output  ADDRESS_BITS  update PC; drives predictor update_pc.
- upd_taken  output  1  actual outcome; drives predictor actual_pred.
- mispred  output  1  misprediction pulse; drives predictor mispred.
- redirect_pc  output  ADDRESS_BITS  correct fetch PC, valid when mispred=1.
- count  output  $clog2(QUEUE_DEPTH)+1  occupied entries.

Function
REQ-005 SHALL keep an in-order circular queue of {pc, pred_taken, pred_target} with wrapping head/tail pointers.
REQ-006 SHALL implement FSM states RUN and RECOVER, with a down-counter for RECOVER.
REQ-007 SHALL drive push_ready = (state==RUN) and count<QUEUE_DEPTH and not reset; no push when full, even with a same-cycle pop.
REQ-008 SHALL drive res_ready = (state==RUN) and count>0 and not reset; res_valid while res_ready=0 SHALL be ignored.
REQ-009 SHALL, on a push and pop in the same cycle, perform both and leave count unchanged.
REQ-010 SHALL flag an accepted resolution as mispredicted if res_taken != head.pred_taken, or if both are taken and res_target != head.pred_target.
REQ-011 SHALL, one cycle after an accepted resolution, pulse upd_valid=1 for exactly one cycle, with upd_pc=head.pc and upd_taken=res_taken.
REQ-012 SHALL, for a mispredicted resolution, assert mispred=1 in the same cycle as upd_valid. redirect_pc SHALL be res_target if res_taken, else head.pc+4, wrapping modulo 2^ADDRESS_BITS.
REQ-013 SHALL, at the clock edge accepting a mispredicted resolution, clear the queue (pointers and count to 0) and drop any same-cycle push. It SHALL enter RECOVER with the counter set to RECOVER_CYCLES.
REQ-014 SHALL, when flush_req=1 in RUN, clear the queue and enter RECOVER identically. A same-cycle correct resolution is dropped (no upd_valid).
REQ-015 SHALL give a mispredicted resolution priority over a concurrent flush_req: upd_valid and mispred are issued, with one RECOVER entry.
REQ-016 SHALL ignore flush_req while in RECOVER; the counter is not reloaded.
REQ-017 SHALL, in RECOVER, decrement the counter each cycle and return to RUN when it reaches 0. push_ready and res_ready SHALL stay 0 for exactly RECOVER_CYCLES cycles after the clearing edge.
REQ-018 SHALL drive count, upd_*, mispred and redirect_pc from registers; push_ready and res_ready SHALL be combinational from state and count.

Reset
REQ-019 SHALL, while reset=1 at a rising edge, set state=RUN, pointers=0, count=0, upd_valid=0, upd_pc=0, upd_taken=0, mispred=0, redirect_pc=0 and RECOVER counter=0.
REQ-020 SHALL take reset priority over all events, including mid-RECOVER. push_ready=1 in the first cycle after reset deasserts.

Verification
REQ-021 Bench SHALL cover: reset; push PCs 0x100,0x104,0x108,0x10C -> count=4, push_ready=0, fifth push not accepted.
REQ-022 Bench SHALL cover: head pred not-taken, res_taken=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=0, mispred=0, count=3.
REQ-023 Bench SHALL cover: head pc 0x100 pred taken to 0x200, res_taken=0 -> mispred=1, redirect_pc=0x104, count=0, push_ready=0 for 2 cycles then 1.
REQ-024 Bench SHALL cover: pred taken 0x200, res taken 0x300 -> mispred=1, redirect_pc=0x300. Pred and actual both taken to 0x200 -> mispred=0.
REQ-025 Bench SHALL cover: count=2, push and correct resolve in one cycle -> count=2, upd_valid=1. Pointer wrap after 6 pushes/pops keeps FIFO order.
REQ-026 Bench SHALL cover: flush_req with mispredicting resolve -> one mispred pulse, single RECOVER of 2 cycles. Reset asserted mid-RECOVER -> push_ready=1 the cycle after deassertion, count=0.

Source files
------------

// File: rtl/branch_update_controller.sv
// Branch update controller: tracks in-flight predicted branches in order and turns
// execute-stage resolutions into predictor updates, misprediction redirects and flush recovery.
module branch_update_controller #(
    parameter int ADDRESS_BITS   = 32,
    parameter int QUEUE_DEPTH    = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push_valid,
    output logic                            push_ready,
    input  logic [ADDRESS_BITS-1:0]         push_pc,
    input  logic                            push_pred_taken,
    input  logic [ADDRESS_BITS-1:0]         push_pred_target,
    input  logic                            res_valid,
    output logic                            res_ready,
    input  logic                            res_taken,
    input  logic [ADDRESS_BITS-1:0]         res_target,
    input  logic                            flush_req,
    output logic                            upd_valid,
    output logic [ADDRESS_BITS-1:0]         upd_pc,
    output logic                            upd_taken,
    output logic                            mispred,
    output logic [ADDRESS_BITS-1:0]         redirect_pc,
    output logic [$clog2(QUEUE_DEPTH):0]    count
);

    localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int REC_BITS = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t                    state;
    logic [REC_BITS-1:0]       rec_cnt;
    logic [PTR_BITS-1:0]       head;
    logic [PTR_BITS-1:0]       tail;

    logic [ADDRESS_BITS-1:0]   q_pc          [QUEUE_DEPTH];
    logic                      q_pred_taken  [QUEUE_DEPTH];
    logic [ADDRESS_BITS-1:0]   q_pred_target [QUEUE_DEPTH];

    logic                      push_fire;
    logic                      pop_fire;
    logic                      is_mispred;
    logic                      clear_queue;
    logic [ADDRESS_BITS-1:0]   head_pc;

    assign push_ready = (state == RUN) && (count < CNT_BITS'(QUEUE_DEPTH)) && !reset;
    assign res_ready  = (state == RUN) && (count != '0) && !reset;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = res_valid && res_ready;
    assign head_pc    = q_pc[head];

    always_comb begin
        is_mispred = 1'b0;
        if (pop_fire) begin
            is_mispred = (res_taken != q_pred_taken[head]) ||
                         (res_taken && (res_target != q_pred_target[head]));
        end
    end

    // A mispredict wins over a concurrent flush, but both clear the queue the same way.
    assign clear_queue = is_mispred || ((state == RUN) && flush_req);

    // NOTE: queue storage has no reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_fire && !clear_queue) begin
            q_pc[tail]          <= push_pc;
            q_pred_taken[tail]  <= push_pred_taken;
            q_pred_target[tail] <= push_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rec_cnt     <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            mispred     <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_valid <= 1'b0;
            mispred   <= 1'b0;

            // A correct resolution that coincides with a flush is discarded.
            if (pop_fire && (is_mispred || !flush_req)) begin
                upd_valid <= 1'b1;
                upd_pc    <= head_pc;
                upd_taken <= res_taken;
                mispred   <= is_mispred;
                if (is_mispred) begin
                    redirect_pc <= res_taken ? res_target : head_pc + ADDRESS_BITS'(4);
                end
            end

            if (clear_queue) begin
                state   <= RECOVER;
                rec_cnt <= REC_BITS'(RECOVER_CYCLES);
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end else if (state == RUN) begin
                if (push_fire) begin
                    tail <= tail + PTR_BITS'(1);
                end
                if (pop_fire) begin
                    head <= head + PTR_BITS'(1);
                end
                if (push_fire && !pop_fire) begin
                    count <= count + CNT_BITS'(1);
                end else if (pop_fire && !push_fire) begin
                    count <= count - CNT_BITS'(1);
                end
            end else begin
                rec_cnt <= rec_cnt - REC_BITS'(1);
                if (rec_cnt == REC_BITS'(1)) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule
